// File: rtl/adc_sample_scheduler.sv
// ADC sample scheduler: shares one conversion engine between two on-demand
// requesters and a periodic round-robin background scan, publishes tagged
// results and tracks per-channel freshness.
module adc_sample_scheduler #(
   parameter int unsigned SCAN_PERIOD    = 50000,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned DATA_W         = 12
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              SCAN_EN,
   input  logic [7:0]        CH_MASK,
   input  logic [1:0]        REQ,
   input  logic [5:0]        REQ_CH,
   output logic [1:0]        ACK,
   output logic              CONV_START,
   output logic [2:0]        CONV_CH,
   input  logic              CONV_BUSY,
   input  logic              CONV_DONE,
   input  logic [DATA_W-1:0] CONV_DATA,
   output logic [DATA_W-1:0] RESULT,
   output logic [2:0]        RESULT_CH,
   output logic              RESULT_VALID,
   output logic [7:0]        CH_VALID,
   output logic              TIMEOUT_ERR
);

   localparam int unsigned ScanW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_PERIOD - 1);
   localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

   state_e            state_q, state_d;
   logic [ScanW-1:0]  scan_cnt_q;
   logic              scan_pend_q;
   logic [2:0]        last_scan_q;
   logic [1:0]        owner_q;        // one-hot requester; 2'b00 means the scan owns it
   logic [2:0]        conv_ch_q;
   logic [ToW-1:0]    to_cnt_q;
   logic [1:0]        ack_q;
   logic [1:0]        ack_prev_q;
   logic [DATA_W-1:0] result_q;
   logic [2:0]        result_ch_q;
   logic [7:0]        ch_valid_q;
   logic              timeout_err_q;

   logic              scan_hit;
   logic [2:0]        scan_ch;
   logic [1:0]        req_eff;
   logic              grant;
   logic              scan_grant;
   logic              scan_drop;
   logic [1:0]        grant_owner;
   logic [2:0]        grant_ch;
   logic              wait_done;
   logic              wait_to;

   // Round-robin pick: first enabled channel strictly after the last scanned one
   always_comb begin
      scan_hit = 1'b0;
      scan_ch  = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         if (!scan_hit && CH_MASK[last_scan_q + 3'(k)]) begin
            scan_hit = 1'b1;
            scan_ch  = last_scan_q + 3'(k);
         end
      end
   end

   // Fixed-priority arbitration in IDLE; a requester just acked is masked so a
   // held level cannot be granted twice for one transaction
   always_comb begin
      req_eff     = REQ & ~(ack_q | ack_prev_q);
      grant       = 1'b0;
      scan_grant  = 1'b0;
      grant_owner = 2'b00;
      grant_ch    = 3'd0;
      scan_drop   = (state_q == StIdle) && scan_pend_q && !scan_hit;
      if (state_q == StIdle) begin
         if (req_eff[0]) begin
            grant       = 1'b1;
            grant_owner = 2'b01;
            grant_ch    = REQ_CH[2:0];
         end else if (req_eff[1]) begin
            grant       = 1'b1;
            grant_owner = 2'b10;
            grant_ch    = REQ_CH[5:3];
         end else if (scan_pend_q && scan_hit) begin
            grant       = 1'b1;
            scan_grant  = 1'b1;
            grant_ch    = scan_ch;
         end
      end
   end

   assign wait_done = (state_q == StWait) && CONV_DONE;
   assign wait_to   = (state_q == StWait) && !CONV_DONE && (to_cnt_q == ToLast);

   // FSM state register
   always_ff @(posedge CLOCK) begin
      if (RESET) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next-state logic; DONE takes precedence over an expiring timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (grant) state_d = StIssue;
         StIssue:   if (!CONV_BUSY) state_d = StWait;
         StWait: begin
            if (CONV_DONE)              state_d = StCapture;
            else if (to_cnt_q == ToLast) state_d = StIdle;
         end
         StCapture: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // FSM outputs decoded from state
   always_comb begin
      CONV_START   = (state_q == StIssue) && !CONV_BUSY;
      RESULT_VALID = (state_q == StCapture);
   end

   // Scan timer and pending flag; a fresh wrap wins over a same-cycle clear
   always_ff @(posedge CLOCK) begin
      if (RESET || !SCAN_EN) begin
         scan_cnt_q  <= '0;
         scan_pend_q <= 1'b0;
      end else begin
         if (scan_cnt_q == ScanLast) begin
            scan_cnt_q  <= '0;
            scan_pend_q <= 1'b1;
         end else begin
            scan_cnt_q <= scan_cnt_q + ScanW'(1);
            if (scan_grant || scan_drop) scan_pend_q <= 1'b0;
         end
      end
   end

   // Grant bookkeeping and the WAIT-state timeout counter
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         last_scan_q <= 3'd7;
         owner_q     <= 2'b00;
         conv_ch_q   <= 3'd0;
         to_cnt_q    <= '0;
      end else begin
         if (grant) begin
            owner_q   <= grant_owner;
            conv_ch_q <= grant_ch;
         end
         if (scan_grant) last_scan_q <= scan_ch;
         if (state_q == StWait) to_cnt_q <= to_cnt_q + ToW'(1);
         else                   to_cnt_q <= '0;
      end
   end

   // Result capture, acknowledge pulse and sticky status flags
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ack_q         <= 2'b00;
         ack_prev_q    <= 2'b00;
         result_q      <= '0;
         result_ch_q   <= 3'd0;
         ch_valid_q    <= 8'h00;
         timeout_err_q <= 1'b0;
      end else begin
         ack_prev_q <= ack_q;
         ack_q      <= (wait_done || wait_to) ? owner_q : 2'b00;
         if (wait_done) begin
            result_q               <= CONV_DATA;
            result_ch_q            <= conv_ch_q;
            ch_valid_q[conv_ch_q]  <= 1'b1;
         end
         if (wait_to) timeout_err_q <= 1'b1;
      end
   end

   assign ACK         = ack_q;
   assign CONV_CH     = conv_ch_q;
   assign RESULT      = result_q;
   assign RESULT_CH   = result_ch_q;
   assign CH_VALID    = ch_valid_q;
   assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Self-checking bench for adc_sample_scheduler: behavioural conversion engine,
// scoreboard of expected result/ack events, table vectors plus corner sequences.
module tb_adc_sample_scheduler;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        SCAN_EN;
   logic [7:0]  CH_MASK;
   logic [1:0]  REQ;
   logic [5:0]  REQ_CH;
   logic [1:0]  ACK;
   logic        CONV_START;
   logic [2:0]  CONV_CH;
   logic        CONV_BUSY;
   logic        CONV_DONE = 1'b0;
   logic [11:0] CONV_DATA = 12'd0;
   logic [11:0] RESULT;
   logic [2:0]  RESULT_CH;
   logic        RESULT_VALID;
   logic [7:0]  CH_VALID;
   logic        TIMEOUT_ERR;

   adc_sample_scheduler #(
      .SCAN_PERIOD   (8),
      .TIMEOUT_CYCLES(16),
      .DATA_W        (12)
   ) dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .SCAN_EN     (SCAN_EN),
      .CH_MASK     (CH_MASK),
      .REQ         (REQ),
      .REQ_CH      (REQ_CH),
      .ACK         (ACK),
      .CONV_START  (CONV_START),
      .CONV_CH     (CONV_CH),
      .CONV_BUSY   (CONV_BUSY),
      .CONV_DONE   (CONV_DONE),
      .CONV_DATA   (CONV_DATA),
      .RESULT      (RESULT),
      .RESULT_CH   (RESULT_CH),
      .RESULT_VALID(RESULT_VALID),
      .CH_VALID    (CH_VALID),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   always #5 CLOCK = ~CLOCK;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic        valid;
      logic [2:0]  ch;
      logic [11:0] data;
      logic [1:0]  ack;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   typedef struct {
      int          idx;
      logic [2:0]  ch;
      int          lat;
      logic [11:0] exp_data;
      logic [1:0]  exp_ack;
      logic [7:0]  exp_chv;
   } vec_t;

   vec_t vt[5];

   // Engine model: returns ch*100 eng_lat cycles after START unless muted
   int         eng_cnt  = 0;
   int         eng_lat  = 2;
   logic       eng_mute = 1'b0;
   logic [2:0] eng_ch   = 3'd0;

   always @(negedge CLOCK) begin
      CONV_DONE = 1'b0;
      if (eng_cnt != 0) begin
         eng_cnt = eng_cnt - 1;
         if (eng_cnt == 0 && !eng_mute) begin
            CONV_DONE = 1'b1;
            CONV_DATA = 12'(eng_ch * 100);
         end
      end
      if (CONV_START === 1'b1) begin
         eng_cnt = eng_lat;
         eng_ch  = CONV_CH;
      end
   end

   // Scoreboard monitor: every RESULT_VALID or ACK pulse must match the queue head
   logic prev_start = 1'b0;

   always @(negedge CLOCK) begin
      if (RESULT_VALID === 1'b1 || (ACK !== 2'b00 && ACK !== 2'bxx)) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: valid=%0b ch=%0d data=%0d ack=%b, none expected",
                     RESULT_VALID, RESULT_CH, RESULT, ACK);
         end else begin
            mon_e = exp_q.pop_front();
            if (RESULT_VALID !== mon_e.valid || ACK !== mon_e.ack ||
                (mon_e.valid && (RESULT_CH !== mon_e.ch || RESULT !== mon_e.data))) begin
               n_fail++;
               $display("FAIL scoreboard: got valid=%0b ch=%0d data=%0d ack=%b, expected valid=%0b ch=%0d data=%0d ack=%b",
                        RESULT_VALID, RESULT_CH, RESULT, ACK,
                        mon_e.valid, mon_e.ch, mon_e.data, mon_e.ack);
            end
         end
      end
      if (CONV_START === 1'b1) begin
         n_vec++;
         if (prev_start) begin
            n_fail++;
            $display("FAIL start_width: CONV_START high 2 cycles, required 1");
         end
      end
      prev_start = (CONV_START === 1'b1);
   end

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic v, input logic [2:0] ch, input logic [11:0] d,
                       input logic [1:0] a);
      exp_t e;
      e.valid = v;
      e.ch    = ch;
      e.data  = d;
      e.ack   = a;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input int i, input int maxc);
      int n = 0;
      do begin
         tick();
         n++;
      end while (ACK[i] !== 1'b1 && n < maxc);
      check("ack_seen", 64'(ACK[i]), 64'd1);
   endtask

   task automatic wait_start(input int maxc);
      int n = 0;
      do begin
         tick();
         n++;
      end while (CONV_START !== 1'b1 && n < maxc);
      check("start_seen", 64'(CONV_START), 64'd1);
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         tick();
         n++;
      end
      tick();
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {ACK, CONV_START, CONV_CH, RESULT, RESULT_CH, RESULT_VALID, CH_VALID,
                   TIMEOUT_ERR}, 64'd0);
   endtask

   initial begin
      int n;
      vt[0] = '{idx: 0, ch: 3'd3, lat: 1, exp_data: 12'd300, exp_ack: 2'b01, exp_chv: 8'h08};
      vt[1] = '{idx: 1, ch: 3'd5, lat: 2, exp_data: 12'd500, exp_ack: 2'b10, exp_chv: 8'h28};
      vt[2] = '{idx: 0, ch: 3'd0, lat: 5, exp_data: 12'd0,   exp_ack: 2'b01, exp_chv: 8'h29};
      vt[3] = '{idx: 1, ch: 3'd7, lat: 3, exp_data: 12'd700, exp_ack: 2'b10, exp_chv: 8'hA9};
      vt[4] = '{idx: 0, ch: 3'd1, lat: 1, exp_data: 12'd100, exp_ack: 2'b01, exp_chv: 8'hAB};

      RESET     = 1'b1;
      SCAN_EN   = 1'b0;
      CH_MASK   = 8'h00;
      REQ       = 2'b00;
      REQ_CH    = 6'o00;
      CONV_BUSY = 1'b0;
      repeat (3) tick();
      RESET = 1'b0;
      check_all_zero("reset_outputs");

      // Scan only: mask 0x85 visits 0,2,7,0
      CH_MASK = 8'h85;
      eng_lat = 2;
      push(1'b1, 3'd0, 12'd0,   2'b00);
      push(1'b1, 3'd2, 12'd200, 2'b00);
      push(1'b1, 3'd7, 12'd700, 2'b00);
      push(1'b1, 3'd0, 12'd0,   2'b00);
      SCAN_EN = 1'b1;
      for (int k = 0; k < 4; k++) wait_start(40);
      SCAN_EN = 1'b0;
      drain(40);
      check("scan_ch_valid", 64'(CH_VALID), 64'h85);

      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check_all_zero("reset2_outputs");

      // Table of single on-demand requests
      for (int v = 0; v < 5; v++) begin
         eng_lat = vt[v].lat;
         REQ_CH  = (vt[v].idx == 0) ? {3'd0, vt[v].ch} : {vt[v].ch, 3'd0};
         REQ     = (vt[v].idx == 0) ? 2'b01 : 2'b10;
         push(1'b1, vt[v].ch, vt[v].exp_data, vt[v].exp_ack);
         wait_ack(vt[v].idx, 40);
         REQ = 2'b00;
         drain(20);
         check("table_ch_valid", 64'(CH_VALID), 64'(vt[v].exp_chv));
      end
      check("no_timeout_yet", 64'(TIMEOUT_ERR), 64'd0);

      // Priority: REQ0 ch3, REQ1 ch5, then the pending scan (ch0)
      eng_lat = 10;
      push(1'b1, 3'd3, 12'd300, 2'b01);
      push(1'b1, 3'd5, 12'd500, 2'b10);
      push(1'b1, 3'd0, 12'd0,   2'b00);
      CH_MASK = 8'h85;
      REQ_CH  = 6'o53;
      REQ     = 2'b11;
      SCAN_EN = 1'b1;
      wait_ack(0, 40);
      REQ[0] = 1'b0;
      wait_ack(1, 40);
      REQ[1] = 1'b0;
      wait_start(10);
      SCAN_EN = 1'b0;
      eng_lat = 2;
      drain(40);

      // Busy stall: START held off for 5 cycles, CONV_CH stable; post-grant REQ changes ignored
      CONV_BUSY = 1'b1;
      REQ_CH    = 6'o04;
      REQ       = 2'b01;
      push(1'b1, 3'd4, 12'd400, 2'b01);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("busy_no_start", 64'(CONV_START), 64'd0);
         check("busy_ch_stable", 64'(CONV_CH), 64'd4);
         if (k == 0) begin
            REQ    = 2'b00;
            REQ_CH = 6'o77;
         end
      end
      tick();
      CONV_BUSY = 1'b0;
      #1;
      check("busy_start", 64'(CONV_START), 64'd1);
      check("busy_start_ch", 64'(CONV_CH), 64'd4);
      tick();
      check("busy_start_once", 64'(CONV_START), 64'd0);
      check("busy_wait_ch", 64'(CONV_CH), 64'd4);
      wait_ack(0, 40);
      drain(20);

      // Timeout: REQ1 ch6 with a silent engine
      eng_mute = 1'b1;
      REQ_CH   = 6'o60;
      REQ      = 2'b10;
      push(1'b0, 3'd0, 12'd0, 2'b10);
      wait_start(10);
      n = 0;
      do begin
         tick();
         n++;
      end while (ACK[1] !== 1'b1 && n < 40);
      REQ = 2'b00;
      check("timeout_latency", 64'(n), 64'd17);
      check("timeout_err", 64'(TIMEOUT_ERR), 64'd1);
      check("timeout_ch_valid", 64'(CH_VALID), 64'hBB);
      check("timeout_result_held", 64'(RESULT), 64'd400);
      eng_mute = 1'b0;
      drain(20);

      // Held REQ0 level: REQ1 slips in after each REQ0 ack
      REQ_CH = 6'o21;
      REQ    = 2'b11;
      push(1'b1, 3'd1, 12'd100, 2'b01);
      push(1'b1, 3'd2, 12'd200, 2'b10);
      push(1'b1, 3'd1, 12'd100, 2'b01);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (ACK[0] === 1'b1) n++;
         if (n == 2) break;
      end
      REQ = 2'b00;
      check("held_acks", 64'(n), 64'd2);
      drain(30);
      check("held_ch_valid", 64'(CH_VALID), 64'hBF);

      // Reset mid-WAIT: no ACK, late DONE ignored, scan restarts at lowest channel
      eng_lat = 6;
      REQ_CH  = 6'o07;
      REQ     = 2'b01;
      wait_start(10);
      REQ = 2'b00;
      tick();
      tick();
      RESET = 1'b1;
      tick();
      check_all_zero("reset_mid_wait");
      RESET = 1'b0;
      repeat (6) tick();
      check_all_zero("late_done_ignored");
      CH_MASK = 8'h05;
      push(1'b1, 3'd0, 12'd0, 2'b00);
      SCAN_EN = 1'b1;
      wait_start(30);
      SCAN_EN = 1'b0;
      drain(30);
      check("scan_restart_ch_valid", 64'(CH_VALID), 64'h01);

      // Empty mask: pending scans are dropped without a conversion
      CH_MASK = 8'h00;
      SCAN_EN = 1'b1;
      n = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (CONV_START === 1'b1) n++;
      end
      SCAN_EN = 1'b0;
      check("empty_mask_no_start", 64'(n), 64'd0);

      tick();
      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
Sequences a single-conversion ADC engine and shares it among two on-demand requesters plus a periodic background scan. The scan covers a configurable mask of the 8 analog channels. It sits between the board-level control logic (buttons, display select) and the serial ADC conversion engine. It publishes each result as a tagged pulse and keeps per-channel freshness flags.

Parameters:
SCAN_PERIOD, 50000, clock cycles between background scan triggers (1 ms at 50 MHz); minimum 2
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before a conversion is abandoned
DATA_W, 12, conversion result width

Ports:
CLOCK  in  1  system clock (50 MHz)
RESET  in  1  synchronous, active-high reset
SCAN_EN  in  1  enables the periodic background scan
CH_MASK  in  8  channels included in the background scan
REQ  in  2  level request per requester; index 0 has highest priority
REQ_CH  in  6  channel per requester: [2:0] for REQ[0], [5:3] for REQ[1]
ACK  out  2  one-cycle pulse ending a granted request (success or timeout)
CONV_START  out  1  one-cycle start strobe to the conversion engine
CONV_CH  out  3  channel to convert; stable from ISSUE through CAPTURE
CONV_BUSY  in  1  engine busy; START is never issued while high
CONV_DONE  in  1  one-cycle pulse: CONV_DATA is valid
CONV_DATA  in  DATA_W  conversion result
RESULT  out  DATA_W  last captured result
RESULT_CH  out  3  channel of RESULT
RESULT_VALID  out  1  one-cycle pulse when RESULT/RESULT_CH update
CH_VALID  out  8  sticky: channel has produced at least one result since reset
TIMEOUT_ERR  out  1  sticky: a conversion timed out

Behaviour:
- Reset values: all outputs 0; FSM IDLE; scan counter 0; scan_pending 0; last_scan_ch 7. Reset mid-conversion abandons it with no ACK.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- Scan timer, SCAN_EN=1:
  - Counts 0..SCAN_PERIOD-1 and wraps.
  - On wrap, sets scan_pending; a wrap while already pending is absorbed.
- Scan timer, SCAN_EN=0: counter held at 0, scan_pending cleared.
- CH_MASK==0 at arbitration: scan_pending is cleared and no conversion is issued.
- Round-robin scan: the next channel is the first CH_MASK bit strictly after last_scan_ch, modulo 8. After reset the first scan converts the lowest enabled channel. last_scan_ch updates at grant.
- IDLE arbitration, fixed priority REQ[0] > REQ[1] > scan_pending:
  - On grant, latch owner and channel (REQ_CH slice, or the scan channel), then go to ISSUE.
  - A scan grant clears scan_pending.
  - REQ[i] is ignored in the IDLE cycle immediately after ACK[i], so a held level does not double-grant.
- ISSUE:
  - If CONV_BUSY=0, CONV_START=1 for this cycle only, then go to WAIT.
  - Otherwise stay in ISSUE with CONV_START=0.
  - The timeout counter does not run in ISSUE.
- WAIT:
  - Timeout counter starts at 0 on entry.
  - CONV_DONE=1: latch CONV_DATA and go to CAPTURE.
  - Counter reaches TIMEOUT_CYCLES-1 without DONE: set TIMEOUT_ERR, pulse ACK[owner] the next cycle if owner is a requester, go to IDLE. No RESULT_VALID, CH_VALID unchanged.
  - If DONE and timeout coincide, DONE wins.
- CAPTURE (1 cycle):
  - RESULT and RESULT_CH are updated.
  - RESULT_VALID=1, CH_VALID[ch] is set, and ACK[owner]=1 if owner is a requester (not the scan).
  - Next state IDLE.
- Latency: grant in IDLE cycle t gives CONV_START at t+1 (if not busy). DONE sampled at cycle d gives RESULT_VALID/ACK at d+1. Minimum request-to-ACK is 3 cycles plus engine time.
- Requests:
  - REQ dropped before grant means the request is withdrawn.
  - After grant, REQ and REQ_CH changes are ignored and ACK still pulses.
- CONV_DONE outside WAIT is ignored.
- RESULT holds its value between pulses.
- TIMEOUT_ERR and CH_VALID clear only on RESET.

Test Plan:
- Scan only: SCAN_PERIOD=8, CH_MASK=8'b1000_0101, engine returns ch*100 → RESULT_CH sequence 0,2,7,0 with RESULT 0,200,700,0; CH_VALID reaches 8'h85.
- Priority: REQ=2'b11 with REQ_CH=6'o53 while scan is pending → ch3 converted first with ACK[0], then ch5 with ACK[1], then the scan. CONV_START pulses are each exactly 1 cycle.
- Busy stall: CONV_BUSY held high for 5 cycles after grant → CONV_START stays 0 through the stall, pulses once on the first not-busy cycle, and CONV_CH is stable throughout.
- Timeout: TIMEOUT_CYCLES=16, engine never asserts DONE for REQ[1] ch6 → ACK[1] pulses 16 cycles after entering WAIT; TIMEOUT_ERR=1; RESULT_VALID=0; CH_VALID[6]=0.
- Held REQ[0] level: REQ[0] kept high for 2 conversions → exactly one ACK per conversion, and the IDLE cycle after each ACK grants the scan or REQ[1] if either is pending.
- Reset mid-WAIT: RESET pulsed for 1 cycle → all outputs 0 the next cycle and no ACK. A late CONV_DONE after reset is ignored; the scan restarts at the lowest enabled channel.
